// File: rtl/vga_timing_gen_if.sv
// Raster bus from vga_timing_gen to the sprite stages and colour mux.
// frame_cnt exists only when FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic [9:0]  xx;
  logic [9:0]  yy;
  logic        aactive;
  logic        aactive_dly;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        animate;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (output xx, yy, aactive, aactive_dly, hsync, vsync,
                  frame_start, animate, frame_cnt);
  modport slave  (input  xx, yy, aactive, aactive_dly, hsync, vsync,
                  frame_start, animate, frame_cnt);
`else
  modport master (output xx, yy, aactive, aactive_dly, hsync, vsync,
                  frame_start, animate);
  modport slave  (input  xx, yy, aactive, aactive_dly, hsync, vsync,
                  frame_start, animate);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with sync/active alignment delay.
// Optional frame counter enabled by defining FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int ALIGN_LAT = 1
) (
  input  logic             Pclk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       running;
  logic [9:0] xx_q, yy_q;

  // First edge out of reset only arms running, so (0,0) is held one extra clock.
  always_ff @(posedge Pclk) begin
    if (reset) begin
      running <= 1'b0;
      xx_q    <= '0;
      yy_q    <= '0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (xx_q == H_MAX) begin
      xx_q <= '0;
      yy_q <= (yy_q == V_MAX) ? 10'd0 : yy_q + 10'd1;
    end else begin
      xx_q <= xx_q + 10'd1;
    end
  end

  logic raw_act, raw_hs_on, raw_vs_on;
  logic [2:0] raw_bits;   // {hsync level, vsync level, active}
  logic [2:0] idle_bits;

  assign raw_act   = running && (xx_q < H_VIS) && (yy_q < V_VIS);
  assign raw_hs_on = running && (xx_q >= HS_BEG) && (xx_q <= HS_END);
  assign raw_vs_on = running && (yy_q >= VS_BEG) && (yy_q <= VS_END);
  assign raw_bits  = {raw_hs_on ? SYNC_POL : ~SYNC_POL,
                      raw_vs_on ? SYNC_POL : ~SYNC_POL,
                      raw_act};
  assign idle_bits = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [2:0] out_bits;

  generate
    if (ALIGN_LAT == 0) begin : g_nodly
      assign out_bits = raw_bits;
    end else begin : g_dly
      logic [ALIGN_LAT-1:0][2:0] align_pipe;

      always_ff @(posedge Pclk) begin
        if (reset) begin
          for (int i = 0; i < ALIGN_LAT; i++) align_pipe[i] <= idle_bits;
        end else begin
          align_pipe[0] <= raw_bits;
          for (int i = 1; i < ALIGN_LAT; i++) align_pipe[i] <= align_pipe[i-1];
        end
      end

      assign out_bits = align_pipe[ALIGN_LAT-1];
    end
  endgenerate

  assign vga.xx          = xx_q;
  assign vga.yy          = yy_q;
  assign vga.aactive     = raw_act;
  assign vga.hsync       = out_bits[2];
  assign vga.vsync       = out_bits[1];
  assign vga.aactive_dly = out_bits[0];
  assign vga.frame_start = running && (xx_q == 10'd0) && (yy_q == 10'd0);
  assign vga.animate     = running && (xx_q == 10'd0) && (yy_q == V_VIS);

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge Pclk) begin
    if (reset)            frame_cnt_q <= '0;
    else if (vga.animate) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two reduced-geometry instances (LAT=1/active-low, LAT=0/active-high)
// checked every cycle against a cycles-since-release reference model.
module tb_vga_timing_gen;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int AN = VA * HT;
  localparam int NCYC = 3000;

  typedef struct {
    logic [9:0]  xx, yy;
    logic        act, act_d, hs, vs, fs, an;
    logic [15:0] fc;
  } exp_t;

  logic Pclk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0, total = 0;
  exp_t qa[$], qb[$];

  always #20 Pclk = ~Pclk;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                   .SYNC_POL(1'b0), .ALIGN_LAT(1))
    dut_a (.Pclk(Pclk), .reset(reset), .vga(ifa));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                   .SYNC_POL(1'b1), .ALIGN_LAT(0))
    dut_b (.Pclk(Pclk), .reset(reset), .vga(ifb));

  // t = clocks since the first unreset edge (-1 while held in reset).
  function automatic exp_t raw_at(int t);
    exp_t r;
    int x, y;
    r = '{default: '0};
    if (t >= 0) begin
      x     = t % HT;
      y     = (t / HT) % VT;
      r.xx  = 10'(x);
      r.yy  = 10'(y);
      r.act = (x < HA) && (y < VA);
      r.hs  = (x >= HA + HFP) && (x < HA + HFP + HS);
      r.vs  = (y >= VA + VFP) && (y < VA + VFP + VS);
      r.fs  = (x == 0) && (y == 0);
      r.an  = (x == 0) && (y == VA);
      r.fc  = (t <= AN) ? 16'd0 : 16'((t - AN - 1) / FT + 1);
    end
    return r;
  endfunction

  function automatic exp_t model(int t, int lat, bit pol);
    exp_t e, d;
    e       = raw_at(t);
    d       = raw_at(t - lat);
    e.act_d = d.act;
    e.hs    = d.hs ? pol : ~pol;
    e.vs    = d.vs ? pol : ~pol;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Pclk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a.xx", 32'(ifa.xx), 32'(e.xx));
        check("a.yy", 32'(ifa.yy), 32'(e.yy));
        check("a.aactive", 32'(ifa.aactive), 32'(e.act));
        check("a.aactive_dly", 32'(ifa.aactive_dly), 32'(e.act_d));
        check("a.hsync", 32'(ifa.hsync), 32'(e.hs));
        check("a.vsync", 32'(ifa.vsync), 32'(e.vs));
        check("a.frame_start", 32'(ifa.frame_start), 32'(e.fs));
        check("a.animate", 32'(ifa.animate), 32'(e.an));
`ifdef FRAME_CNT_EN
        check("a.frame_cnt", 32'(ifa.frame_cnt), 32'(e.fc));
`endif
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b.xx", 32'(ifb.xx), 32'(e.xx));
        check("b.yy", 32'(ifb.yy), 32'(e.yy));
        check("b.aactive", 32'(ifb.aactive), 32'(e.act));
        check("b.aactive_dly", 32'(ifb.aactive_dly), 32'(e.act_d));
        check("b.hsync", 32'(ifb.hsync), 32'(e.hs));
        check("b.vsync", 32'(ifb.vsync), 32'(e.vs));
        check("b.frame_start", 32'(ifb.frame_start), 32'(e.fs));
        check("b.animate", 32'(ifb.animate), 32'(e.an));
`ifdef FRAME_CNT_EN
        check("b.frame_cnt", 32'(ifb.frame_cnt), 32'(e.fc));
`endif
      end
    end
  end

  // Stimulus: 5-clock reset, then free run with a forced mid-frame reset and random ones.
  initial begin
    int t = -1;
    int rst_left = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge Pclk);
      if (c < 5) reset = 1'b1;
      else if (rst_left > 0) begin
        reset = 1'b1;
        rst_left--;
      end else if (c == 1500 || $urandom_range(0, 699) == 0) begin
        reset    = 1'b1;
        rst_left = (c == 1500) ? 0 : int'($urandom_range(0, 2));
      end else reset = 1'b0;
      @(posedge Pclk);
      t = reset ? -1 : t + 1;
      qa.push_back(model(t, 1, 1'b0));
      qb.push_back(model(t, 0, 1'b1));
    end
    @(negedge Pclk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
